icache_dm: RTL



---
 rtl/icache_dm.sv | 121 ++++++++++++
 1 files changed

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped instruction cache with whole-line refill.
// A one-entry stage register holds the accepted PC; hits respond the next cycle.
module icache_dm #(
   parameter int ADDR       = 32,
   parameter int INST       = 32,
   parameter int SETS       = 64,
   parameter int LINE_WORDS = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            fetch_e_,
   input  logic [ADDR-1:0] fetch_pc,
   input  logic            ic_flush,
   output logic            ic_busy,
   output logic            ic_e_,
   output logic [ADDR-1:0] ic_pc,
   output logic [INST-1:0] ic_inst,
   output logic            mem_req,
   output logic [ADDR-1:0] mem_addr,
   input  logic            mem_gnt,
   input  logic            mem_rvalid,
   input  logic [INST-1:0] mem_rdata
);
   localparam int OFF_W  = $clog2(LINE_WORDS);
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_LO = OFF_W + IDX_W + 2;
   localparam int TAG_W  = ADDR - TAG_LO;

   localparam logic [1:0] RUN   = 2'd0;
   localparam logic [1:0] MREQ  = 2'd1;
   localparam logic [1:0] MDATA = 2'd2;

   logic [1:0]       state;
   logic             s_v;
   logic [ADDR-1:0]  s_pc;
   logic [SETS-1:0]  valid;
   logic [TAG_W-1:0] tag_mem [SETS];
   logic [INST-1:0]  data_mem [SETS*LINE_WORDS];
   logic [OFF_W-1:0] beat;
   logic             drop;

   logic [IDX_W-1:0] idx;
   logic [OFF_W-1:0] off;
   logic [TAG_W-1:0] tag;
   logic             hit;
   logic             accept;
   logic             beat_we;
   logic             fill_done;

   assign idx = s_pc[TAG_LO-1:OFF_W+2];
   assign off = s_pc[OFF_W+1:2];
   assign tag = s_pc[ADDR-1:TAG_LO];

   assign hit = (state == RUN) && s_v && valid[idx] && (tag_mem[idx] == tag);

   always_comb begin
      ic_busy = 1'b1;
      if (state == RUN)
         ic_busy = ic_flush || (s_v && !hit);
   end

   assign accept   = !fetch_e_ && !ic_busy && !ic_flush;
   assign ic_e_    = !hit;
   assign ic_pc    = hit ? s_pc : '0;
   assign ic_inst  = hit ? data_mem[{idx, off}] : '0;
   assign mem_req  = (state == MREQ);
   assign mem_addr = mem_req ? {s_pc[ADDR-1:OFF_W+2], {(OFF_W+2){1'b0}}} : '0;

   // A beat presented together with the grant is already part of the line.
   assign beat_we   = mem_rvalid && ((state == MREQ && mem_gnt) || state == MDATA);
   assign fill_done = beat_we && (state == MDATA) && (beat == OFF_W'(LINE_WORDS - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
         s_v   <= 1'b0;
         s_pc  <= '0;
         valid <= '0;
         beat  <= '0;
         drop  <= 1'b0;
      end else begin
         if (fill_done)
            beat <= '0;
         else if (beat_we)
            beat <= beat + OFF_W'(1);

         case (state)
            RUN:     if (!ic_flush && s_v && !hit) state <= MREQ;
            MREQ:    if (mem_gnt) state <= MDATA;
            MDATA:   if (fill_done) state <= RUN;
            default: state <= RUN;
         endcase

         if (ic_flush)
            s_v <= 1'b0;
         else if (state == RUN && !ic_busy)
            s_v <= accept;

         if (accept)
            s_pc <= fetch_pc;

         // Flush beats a same-cycle line completion; a dropped refill never validates.
         if (ic_flush)
            valid <= '0;
         else if (fill_done && !drop)
            valid[idx] <= 1'b1;

         if (fill_done)
            drop <= 1'b0;
         else if (ic_flush && state != RUN)
            drop <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (fill_done)
         tag_mem[idx] <= tag;
      if (beat_we)
         data_mem[{idx, beat}] <= mem_rdata;
   end
endmodule
